// File: rtl/sram_dualport_pipe.sv
// Simple-dual-port SRAM with a fixed-latency read pipeline, selectable
// read-during-write policy, a per-read tag and an in-flight read counter.
module sram_dualport_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LATENCY  = 5,
    parameter int unsigned RDW_MODE = 0,
    parameter int unsigned TAG_W    = 1,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned CNT_W    = $clog2(LATENCY + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              ren_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic [WIDTH-1:0]  data_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              vld_o,
    output logic [CNT_W-1:0]  inflight_o
);

    if (LATENCY < 1) begin : g_bad_latency
        $error("sram_dualport_pipe: LATENCY must be at least 1");
    end

    // One extra bit so a power-of-two DEPTH does not wrap to zero.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]   data_q [LATENCY];
    logic [TAG_W-1:0]   tag_q  [LATENCY];
    logic [CNT_W-1:0]   cnt_q;

    logic             wr_ok;
    logic             rd_ok;
    logic             rdw_hit;
    logic [WIDTH-1:0] rd_word;

    always_comb begin
        wr_ok   = wen_i && ({1'b0, waddr_i} < DEPTH_L);
        rd_ok   = {1'b0, raddr_i} < DEPTH_L;
        rdw_hit = (RDW_MODE != 0) && wr_ok && (waddr_i == raddr_i);
        rd_word = '0;
        if (rdw_hit) begin
            rd_word = data_i;
        end else if (rd_ok) begin
            rd_word = mem[raddr_i];
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[waddr_i] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int unsigned k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            vld_q[0] <= ren_i;
            if (ren_i) begin
                data_q[0] <= rd_word;
                tag_q[0]  <= tag_i;
            end
            // Stages only load behind a moving valid bit, so idle cycles hold.
            for (int unsigned k = 1; k < LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                    tag_q[k]  <= tag_q[k-1];
                end
            end
            case ({ren_i, vld_o})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign vld_o      = vld_q[LATENCY-1];
    assign data_o     = data_q[LATENCY-1];
    assign tag_o      = tag_q[LATENCY-1];
    assign inflight_o = cnt_q;

endmodule

// File: tb/tb_sram_dualport_pipe.sv
// Bench for sram_dualport_pipe: three instances (old-data, new-data, LATENCY=1)
// checked every cycle against a history-array model plus directed literal checks.
module tb_sram_dualport_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_wen, a_ren, a_tag;
    logic [2:0] a_waddr, a_raddr;
    logic [7:0] a_wd;
    logic        b_wen, b_ren;
    logic [2:0]  b_waddr, b_raddr;
    logic [15:0] b_wd;
    logic [1:0]  b_tag;

    logic [7:0]  d0, d1;
    logic        t0, t1, v0, v1;
    logic [2:0]  c0, c1;
    logic [15:0] d2;
    logic [1:0]  t2;
    logic        v2;
    logic [0:0]  c2;

    sram_dualport_pipe #(.WIDTH(8), .DEPTH(8), .LATENCY(5), .RDW_MODE(0), .TAG_W(1)) u_rdw0 (
        .clk_i(clk), .rst_ni(rst_n), .wen_i(a_wen), .waddr_i(a_waddr), .data_i(a_wd),
        .ren_i(a_ren), .raddr_i(a_raddr), .tag_i(a_tag),
        .data_o(d0), .tag_o(t0), .vld_o(v0), .inflight_o(c0));

    sram_dualport_pipe #(.WIDTH(8), .DEPTH(8), .LATENCY(5), .RDW_MODE(1), .TAG_W(1)) u_rdw1 (
        .clk_i(clk), .rst_ni(rst_n), .wen_i(a_wen), .waddr_i(a_waddr), .data_i(a_wd),
        .ren_i(a_ren), .raddr_i(a_raddr), .tag_i(a_tag),
        .data_o(d1), .tag_o(t1), .vld_o(v1), .inflight_o(c1));

    sram_dualport_pipe #(.WIDTH(16), .DEPTH(6), .LATENCY(1), .RDW_MODE(0), .TAG_W(2)) u_lat1 (
        .clk_i(clk), .rst_ni(rst_n), .wen_i(b_wen), .waddr_i(b_waddr), .data_i(b_wd),
        .ren_i(b_ren), .raddr_i(b_raddr), .tag_i(b_tag),
        .data_o(d2), .tag_o(t2), .vld_o(v2), .inflight_o(c2));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int unsigned lat_of(input int i);
        return (i == 2) ? 1 : 5;
    endfunction
    function automatic int unsigned dep_of(input int i);
        return (i == 2) ? 6 : 8;
    endfunction

    // Model: per-edge history of accepted reads; result of edge e appears after edge e+LAT-1.
    bit        hv [3][8];
    bit [15:0] hd [3][8];
    bit [1:0]  ht [3][8];
    bit [15:0] mm [3][8];
    bit [15:0] last_d [3];
    bit [1:0]  last_t [3];
    int unsigned cyc = 8;
    int unsigned rst_cnt = 0;
    int unsigned seen_rst = 0;

    always @(negedge rst_n) rst_cnt++;

    always @(posedge clk) begin
        logic        mw, mr;
        logic [2:0]  mwa, mra;
        logic [15:0] mwd, av, ad, at, ac;
        logic [1:0]  mt;
        int unsigned slot, os, inf;
        bit          ev;
        cyc++;
        slot = cyc % 8;
        if (!rst_n || rst_cnt != seen_rst) begin
            seen_rst = rst_cnt;
            for (int i = 0; i < 3; i++) begin
                for (int s = 0; s < 8; s++) hv[i][s] = 1'b0;
                last_d[i] = '0;
                last_t[i] = '0;
            end
        end
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (i < 2) begin
                    mw = a_wen; mwa = a_waddr; mwd = {8'h00, a_wd};
                    mr = a_ren; mra = a_raddr; mt = {1'b0, a_tag};
                end else begin
                    mw = b_wen; mwa = b_waddr; mwd = b_wd;
                    mr = b_ren; mra = b_raddr; mt = b_tag;
                end
                hv[i][slot] = mr;
                if (mr) begin
                    ht[i][slot] = mt;
                    if (32'(mra) >= dep_of(i))
                        hd[i][slot] = '0;
                    else if (i == 1 && mw && mwa == mra)
                        hd[i][slot] = mwd;
                    else
                        hd[i][slot] = mm[i][mra];
                end
                if (mw && 32'(mwa) < dep_of(i)) mm[i][mwa] = mwd;
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            os  = (cyc + 1 - lat_of(i)) % 8;
            ev  = hv[i][os];
            inf = 0;
            for (int unsigned j = 0; j < lat_of(i); j++) inf += 32'(hv[i][(cyc - j) % 8]);
            if (ev) begin
                last_d[i] = hd[i][os];
                last_t[i] = ht[i][os];
            end
            case (i)
                0:       begin av = 16'(v0); ad = 16'(d0); at = 16'(t0); ac = 16'(c0); end
                1:       begin av = 16'(v1); ad = 16'(d1); at = 16'(t1); ac = 16'(c1); end
                default: begin av = 16'(v2); ad = d2;      at = 16'(t2); ac = 16'(c2); end
            endcase
            chk($sformatf("u%0d vld cyc%0d", i, cyc), 32'(av), 32'(ev));
            chk($sformatf("u%0d data cyc%0d", i, cyc), 32'(ad), 32'(last_d[i]));
            chk($sformatf("u%0d tag cyc%0d", i, cyc), 32'(at), 32'(last_t[i]));
            chk($sformatf("u%0d inflight cyc%0d", i, cyc), 32'(ac), inf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        a_wen = 1'b0; a_ren = 1'b0;
        b_wen = 1'b0; b_ren = 1'b0;
    endtask

    initial begin
        int got, maxc, first, lastv;
        a_waddr = '0; a_raddr = '0; a_wd = '0; a_tag = '0;
        b_waddr = '0; b_raddr = '0; b_wd = '0; b_tag = '0;
        idle();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("reset vld", 32'(v0), 0);
        chk("reset inflight", 32'(c0), 0);
        chk("reset data", 32'(d0), 0);

        // 1: single read latency
        a_wen = 1'b1; a_waddr = 3'd3; a_wd = 8'hA5; tick(); idle();
        a_ren = 1'b1; a_raddr = 3'd3; a_tag = 1'b1; tick(); idle();
        chk("t1 inflight T", 32'(c0), 1);
        chk("t1 vld T", 32'(v0), 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("t1 inflight T+%0d", k), 32'(c0), 1);
            chk($sformatf("t1 vld T+%0d", k), 32'(v0), (k == 4) ? 1 : 0);
        end
        chk("t1 data", 32'(d0), 32'h A5);
        chk("t1 tag", 32'(t0), 1);
        tick();
        chk("t1 vld after", 32'(v0), 0);
        chk("t1 inflight after", 32'(c0), 0);
        chk("t1 data hold", 32'(d0), 32'hA5);

        // 2: streaming
        for (int i = 0; i < 8; i++) begin
            a_wen = 1'b1; a_waddr = 3'(i); a_wd = 8'(16 + i); tick();
        end
        idle();
        got = 0; maxc = 0; first = -1; lastv = -1;
        for (int n = 0; n < 20; n++) begin
            a_ren = (n < 8); a_raddr = 3'(n); a_tag = 1'(n);
            tick();
            if (v0) begin
                chk($sformatf("t2 data %0d", got), 32'(d0), 32'(16 + got));
                got++;
                if (first < 0) first = n;
                lastv = n;
            end
            if (int'(c0) > maxc) maxc = int'(c0);
        end
        idle();
        chk("t2 count", 32'(got), 8);
        chk("t2 first", 32'(first), 4);
        chk("t2 span", 32'(lastv - first), 7);
        chk("t2 max inflight", 32'(maxc), 5);
        chk("t2 final inflight", 32'(c0), 0);

        // 3: read during write
        a_wen = 1'b1; a_waddr = 3'd2; a_wd = 8'h11; tick();
        a_wd = 8'h22; a_ren = 1'b1; a_raddr = 3'd2; a_tag = 1'b0; tick(); idle();
        repeat (4) tick();
        chk("t3 vld0", 32'(v0), 1);
        chk("t3 vld1", 32'(v1), 1);
        chk("t3 old data", 32'(d0), 32'h11);
        chk("t3 new data", 32'(d1), 32'h22);
        a_ren = 1'b1; tick(); idle();
        repeat (4) tick();
        chk("t3 reread0", 32'(d0), 32'h22);
        chk("t3 reread1", 32'(d1), 32'h22);

        // 4: reset mid-flight
        a_wen = 1'b1; a_waddr = 3'd3; a_wd = 8'hA5; tick(); idle();
        for (int i = 0; i < 3; i++) begin
            a_ren = 1'b1; a_raddr = 3'd3; a_tag = 1'(i); tick();
        end
        idle();
        chk("t4 inflight pre", 32'(c0), 3);
        #1 rst_n = 1'b0;
        #1;
        chk("t4 vld async", 32'(v0), 0);
        chk("t4 inflight async", 32'(c0), 0);
        chk("t4 inflight1 async", 32'(c1), 0);
        chk("t4 data async", 32'(d0), 0);
        tick();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("t4 no pulse %0d", k), 32'(v0), 0);
        end
        a_ren = 1'b1; a_raddr = 3'd3; a_tag = 1'b1; tick(); idle();
        repeat (4) tick();
        chk("t4 fresh vld", 32'(v0), 1);
        chk("t4 retained", 32'(d0), 32'hA5);

        // 5: LATENCY=1, DEPTH=6, WIDTH=16
        b_wen = 1'b1; b_waddr = 3'd1; b_wd = 16'hBEEF; tick(); b_wen = 1'b0;
        b_ren = 1'b1; b_raddr = 3'd1; b_tag = 2'd2; tick(); b_ren = 1'b0;
        chk("t5 vld", 32'(v2), 1);
        chk("t5 data", 32'(d2), 32'hBEEF);
        chk("t5 tag", 32'(t2), 2);
        chk("t5 inflight", 32'(c2), 1);
        tick();
        chk("t5 vld drop", 32'(v2), 0);
        chk("t5 inflight drop", 32'(c2), 0);
        b_wen = 1'b1; b_waddr = 3'd7; b_wd = 16'h1234; tick(); b_wen = 1'b0;
        b_ren = 1'b1; b_raddr = 3'd7; b_tag = 2'd1; tick();
        chk("t5 oob vld", 32'(v2), 1);
        chk("t5 oob data", 32'(d2), 0);
        b_raddr = 3'd1; tick(); b_ren = 1'b0;
        chk("t5 no alias", 32'(d2), 32'hBEEF);

        // 6: random traffic, checked by the per-cycle model
        for (int i = 0; i < 6; i++) begin
            b_wen = 1'b1; b_waddr = 3'(i); b_wd = 16'(i * 16'h0101); tick();
        end
        idle();
        repeat (10000) begin
            a_wen = 1'($urandom_range(0, 1)); a_waddr = 3'($urandom_range(0, 7));
            a_wd = 8'($urandom);              a_ren = 1'($urandom_range(0, 1));
            a_raddr = 3'($urandom_range(0, 7)); a_tag = 1'($urandom_range(0, 1));
            b_wen = 1'($urandom_range(0, 1)); b_waddr = 3'($urandom_range(0, 7));
            b_wd = 16'($urandom);             b_ren = 1'($urandom_range(0, 1));
            b_raddr = 3'($urandom_range(0, 7)); b_tag = 2'($urandom_range(0, 3));
            tick();
        end
        idle();
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
